// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: hex segment table,
// all-off patterns, FSM state encoding and the display bank layout.
// Segment patterns are active-low in gfedcba order (bit 0 = segment a).
package seg7_pkg;

  // Entry n is the active-low pattern for hex digit n.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  typedef enum logic {
    SHOW = 1'b0,
    DEAD = 1'b1
  } state_t;

  // One display frame's worth of data (shadow and active banks).
  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lz_en;
  } bank_t;

endpackage

// File: rtl/seg7_hex_decode.sv
// Purpose: combinational hex nibble to active-low 7-segment pattern.
// Latency: combinational, no state.
// Backpressure: none.
// Ports: nibble (4-bit hex digit in), seg (active-low gfedcba out).
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/led7seg_scan4.sv
// Purpose: 4-digit common-anode 7-segment scan driver with dead-time and
//          double-buffered display data.
// Latency: scan_clk rise to next digit lit = 2 sync edges + DEAD_CYCLES + 1.
// Backpressure: none; load is accepted every cycle, ticks during dead-time drop.
// Ports: clk, rst (async, active-high), scan_clk (async level), value/dp_in/
//        blank/lz_en (frame data), load (capture strobe), an/seg/dp (active-low).
module led7seg_scan4
  import seg7_pkg::*;
#(
  parameter int unsigned DEAD_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scan_clk,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank,
  input  logic        lz_en,
  input  logic        load,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam logic [7:0] DEAD_LAST = 8'(DEAD_CYCLES - 1);

  logic       s1, s2, s3;
  logic       tick;
  bank_t      shadow, active;
  state_t     state, state_nxt;
  logic [7:0] dead_cnt, dead_cnt_nxt;
  logic [1:0] digit, digit_nxt;
  logic       frame_copy;
  logic [3:0] an_nxt;
  logic [6:0] seg_nxt;
  logic       dp_nxt;

  // scan_clk is asynchronous: two-flop synchronizer plus a delay stage for
  // rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= scan_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick = s2 & ~s3;

  // Display content for the current digit, taken from the active bank.
  logic [3:0] nibble;
  logic [6:0] hex_seg;
  logic [3:0] lz_zero;
  logic       dark;
  logic [3:0] an_lit;
  logic [6:0] seg_lit;
  logic       dp_lit;

  assign nibble = active.value[{digit, 2'b00} +: 4];

  seg7_hex_decode u_dec (
    .nibble (nibble),
    .seg    (hex_seg)
  );

  // lz_zero[i]: nibble i and every higher nibble are zero. digit0 never blanks.
  assign lz_zero[3] = (active.value[15:12] == 4'h0);
  assign lz_zero[2] = lz_zero[3] & (active.value[11:8] == 4'h0);
  assign lz_zero[1] = lz_zero[2] & (active.value[7:4] == 4'h0);
  assign lz_zero[0] = 1'b0;

  assign dark    = active.blank[digit] | (active.lz_en & lz_zero[digit]);
  assign an_lit  = ~(4'b0001 << digit);
  assign seg_lit = dark ? SEG_OFF : hex_seg;
  assign dp_lit  = dark ? 1'b1 : ~active.dp[digit];

  always_comb begin
    state_nxt    = state;
    dead_cnt_nxt = dead_cnt;
    digit_nxt    = digit;
    an_nxt       = an;
    seg_nxt      = seg;
    dp_nxt       = dp;
    frame_copy   = 1'b0;
    case (state)
      SHOW: begin
        if (tick) begin
          state_nxt    = DEAD;
          dead_cnt_nxt = 8'd0;
          digit_nxt    = digit + 2'd1;
          an_nxt       = AN_OFF;
          seg_nxt      = SEG_OFF;
          dp_nxt       = 1'b1;
          frame_copy   = (digit == 2'd3);
        end
      end
      DEAD: begin
        // Ticks are ignored here; the counter alone ends the dead-time.
        dead_cnt_nxt = dead_cnt + 8'd1;
        if (dead_cnt == DEAD_LAST) begin
          state_nxt = SHOW;
          an_nxt    = an_lit;
          seg_nxt   = seg_lit;
          dp_nxt    = dp_lit;
        end
      end
      default: state_nxt = DEAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= DEAD;
      dead_cnt <= 8'd0;
      digit    <= 2'd0;
      an       <= AN_OFF;
      seg      <= SEG_OFF;
      dp       <= 1'b1;
    end else begin
      state    <= state_nxt;
      dead_cnt <= dead_cnt_nxt;
      digit    <= digit_nxt;
      an       <= an_nxt;
      seg      <= seg_nxt;
      dp       <= dp_nxt;
    end
  end

  // Active takes the pre-load shadow when load and frame copy coincide,
  // so a late load waits one full frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
      active <= '0;
    end else begin
      if (load) begin
        shadow.value <= value;
        shadow.dp    <= dp_in;
        shadow.blank <= blank;
        shadow.lz_en <= lz_en;
      end
      if (frame_copy) begin
        active <= shadow;
      end
    end
  end

endmodule

// File: tb/tb_led7seg_scan4.sv
module tb_led7seg_scan4;

  localparam int DEAD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        scan_clk = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank = '0;
  logic        lz_en = 1'b0;
  logic        load = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int compared = 0;
  int mismatched = 0;
  logic scan_en = 1'b0;
  int gcnt = 0;

  led7seg_scan4 #(.DEAD_CYCLES(DEAD)) dut (
    .clk      (clk),
    .rst      (rst),
    .scan_clk (scan_clk),
    .value    (value),
    .dp_in    (dp_in),
    .blank    (blank),
    .lz_en    (lz_en),
    .load     (load),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  always #5 clk = ~clk;

  // Free-running scan clock: 10 cycles low, 10 cycles high.
  always @(negedge clk) begin
    if (scan_en) begin
      scan_clk = (gcnt >= 10);
      gcnt = (gcnt + 1) % 20;
    end else begin
      gcnt = 0;
    end
  end

  // ---------------- behavioural model ----------------
  int hex_tab [16] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78,
                       'h00, 'h10, 'h08, 'h03, 'h46, 'h21, 'h06, 'h0E};

  int m_prev = 0, m_r1 = 0, m_r2 = 0;
  int m_lit = 0, m_elapsed = 0, m_digit = 0;
  int sh_val = 0, sh_dp = 0, sh_blank = 0, sh_lz = 0;
  int ac_val = 0, ac_dp = 0, ac_blank = 0, ac_lz = 0;
  int e_an = 'hF, e_seg = 'h7F, e_dp = 1;

  // What digit d must look like given the active frame data.
  task automatic model_show(input int d);
    int nib;
    bit off;
    nib  = (ac_val >> (4 * d)) & 15;
    off  = ((ac_blank >> d) & 1) == 1 || (ac_lz != 0 && d > 0 && (ac_val >> (4 * d)) == 0);
    e_an = (~(1 << d)) & 'hF;
    e_seg = off ? 'h7F : hex_tab[nib];
    e_dp  = off ? 1 : (((ac_dp >> d) & 1) == 1 ? 0 : 1);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_prev = 0; m_r1 = 0; m_r2 = 0;
      m_lit = 0; m_elapsed = 0; m_digit = 0;
      sh_val = 0; sh_dp = 0; sh_blank = 0; sh_lz = 0;
      ac_val = 0; ac_dp = 0; ac_blank = 0; ac_lz = 0;
      e_an = 'hF; e_seg = 'h7F; e_dp = 1;
    end else begin
      int act;
      // A rise seen at one edge is acted upon two edges later.
      act = m_r2;
      m_r2 = m_r1;
      m_r1 = (scan_clk && m_prev == 0) ? 1 : 0;
      m_prev = scan_clk ? 1 : 0;
      if (m_lit != 0) begin
        if (act != 0) begin
          m_lit = 0;
          m_elapsed = 0;
          if (m_digit == 3) begin
            ac_val = sh_val; ac_dp = sh_dp; ac_blank = sh_blank; ac_lz = sh_lz;
          end
          m_digit = (m_digit + 1) % 4;
          e_an = 'hF; e_seg = 'h7F; e_dp = 1;
        end
      end else begin
        m_elapsed++;
        if (m_elapsed == DEAD) begin
          m_lit = 1;
          model_show(m_digit);
        end
      end
      if (load) begin
        sh_val = int'(value); sh_dp = int'(dp_in); sh_blank = int'(blank); sh_lz = int'(lz_en);
      end
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("model_an", int'(an), e_an);
      check("model_seg", int'(seg), e_seg);
      check("model_dp", int'(dp), e_dp);
    end
  end

  // Wait through the next dead interval and check the digit that follows.
  task automatic wait_show(input string nm, input int exp_dead, input int ean,
                           input int eseg, input int edp);
    int n = 0;
    int guard = 0;
    while (an != 4'hF && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    while (an == 4'hF && guard < 200) begin
      n++;
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      compared++;
      mismatched++;
      $display("FAIL %s: timeout waiting for digit, an=%0h", nm, an);
    end else begin
      check({nm, "_dead"}, n, exp_dead);
      check({nm, "_an"}, int'(an), ean);
      check({nm, "_seg"}, int'(seg), eseg);
      check({nm, "_dp"}, int'(dp), edp);
    end
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] d,
                            input logic [3:0] b, input logic lz);
    value = v; dp_in = d; blank = b; lz_en = lz; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    @(negedge clk);
    check("rst_an", int'(an), 'hF);
    check("rst_seg", int'(seg), 'h7F);
    check("rst_dp", int'(dp), 1);
    @(negedge clk);
    rst = 1'b0;
    wait_show("boot_d0", DEAD, 'hE, 'h40, 1);

    // Frame data loaded mid-frame appears only after the 3->0 advance.
    pulse_load(16'h12AF, 4'b0100, 4'b0000, 1'b0);
    scan_en = 1'b1;
    wait_show("old_d1", DEAD, 'hD, 'h40, 1);
    wait_show("old_d2", DEAD, 'hB, 'h40, 1);
    wait_show("old_d3", DEAD, 'h7, 'h40, 1);
    for (int f = 0; f < 2; f++) begin
      wait_show("a_d0", DEAD, 'hE, 'h0E, 1);
      wait_show("a_d1", DEAD, 'hD, 'h08, 1);
      wait_show("a_d2", DEAD, 'hB, 'h24, 0);
      wait_show("a_d3", DEAD, 'h7, 'h79, 1);
    end

    // Leading-zero suppression on, then off with digit3 forced blank.
    pulse_load(16'h0070, 4'b0000, 4'b0000, 1'b1);
    wait_show("lz_d0", DEAD, 'hE, 'h40, 1);
    wait_show("lz_d1", DEAD, 'hD, 'h78, 1);
    wait_show("lz_d2", DEAD, 'hB, 'h7F, 1);
    wait_show("lz_d3", DEAD, 'h7, 'h7F, 1);
    pulse_load(16'h0070, 4'b0000, 4'b1000, 1'b0);
    wait_show("nlz_d0", DEAD, 'hE, 'h40, 1);
    wait_show("nlz_d1", DEAD, 'hD, 'h78, 1);
    wait_show("nlz_d2", DEAD, 'hB, 'h40, 1);
    wait_show("nlz_d3", DEAD, 'h7, 'h7F, 1);

    // Load coinciding with the 3->0 advance.
    scan_en = 1'b0;
    scan_clk = 1'b0;
    repeat (25) @(negedge clk);
    scan_clk = 1'b1;            // sampled at edge N
    @(negedge clk);
    @(negedge clk);
    value = 16'h3456; dp_in = 4'b0000; blank = 4'b0000; lz_en = 1'b0;
    load = 1'b1;                // sampled at edge N+2, same edge as the advance
    @(negedge clk);
    load = 1'b0;
    scan_clk = 1'b0;
    wait_show("col_d0", DEAD, 'hE, 'h40, 1);
    scan_en = 1'b1;
    wait_show("col_d1", DEAD, 'hD, 'h78, 1);
    wait_show("col_d2", DEAD, 'hB, 'h40, 1);
    wait_show("col_d3", DEAD, 'h7, 'h7F, 1);
    wait_show("new_d0", DEAD, 'hE, 'h02, 1);
    wait_show("new_d1", DEAD, 'hD, 'h12, 1);
    wait_show("new_d2", DEAD, 'hB, 'h19, 1);
    wait_show("new_d3", DEAD, 'h7, 'h30, 1);

    // Second rise during dead-time must be dropped.
    scan_en = 1'b0;
    scan_clk = 1'b0;
    repeat (25) @(negedge clk);
    scan_clk = 1'b1;            // edge N
    @(negedge clk);
    scan_clk = 1'b0;
    @(negedge clk);
    @(negedge clk);             // after N+2: dead-time in progress
    scan_clk = 1'b1;            // edge N+3, tick falls inside dead-time
    @(negedge clk);
    scan_clk = 1'b0;
    wait_show("drop_d0", DEAD - 1, 'hE, 'h02, 1);
    repeat (20) @(negedge clk);
    check("drop_hold_an", int'(an), 'hE);

    // Asynchronous reset while digit2 is lit.
    scan_en = 1'b1;
    wait_show("pre_d1", DEAD, 'hD, 'h12, 1);
    wait_show("pre_d2", DEAD, 'hB, 'h19, 1);
    scan_en = 1'b0;
    scan_clk = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_an", int'(an), 'hF);
    check("mid_rst_seg", int'(seg), 'h7F);
    check("mid_rst_dp", int'(dp), 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_show("post_rst_d0", DEAD, 'hE, 'h40, 1);
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
